instr_fetch_buf: RTL and testbench
==================================

INSTR_FETCH_BUF -- requirements
Module: instr_fetch_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter BOOT_ADDR, default 32'h80, first fetch address after reset.
REQ-003 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_i  input  1  core enables fetching.
REQ-006 SHALL have port branch_i  input  1  core redirect pulse.
REQ-007 SHALL have port branch_addr_i  input  32  redirect target.
REQ-008 SHALL have port ready_i  input  1  core accepts head entry.
REQ-009 SHALL have port valid_o  output  1  head entry valid.
REQ-010 SHALL have port rdata_o  output  32  head instruction word.
REQ-011 SHALL have port addr_o  output  32  head instruction address.
REQ-012 SHALL have port instr_req_o  output  1  memory fetch request.
REQ-013 SHALL have port instr_addr_o  output  32  memory fetch address, bits[1:0]=0.
REQ-014 SHALL have port instr_gnt_i  input  1  memory grant, registered, with data.
REQ-015 SHALL have port instr_rdata_i  input  32  memory data, valid when instr_gnt_i=1.

Function
REQ-016 SHALL treat a request issued in cycle N as answered in cycle N+1: instr_gnt_i=1 means instr_rdata_i is the word at the cycle-N address.
REQ-017 SHALL keep at most one request outstanding; instr_req_o asserts only when req_i=1 and (count + outstanding) < DEPTH.
REQ-018 SHALL hold fetch PC fpc; instr_addr_o = fpc; fpc increments by 4 (mod 2^32) in each cycle instr_req_o=1 and no branch.
REQ-019 SHALL, if outstanding and instr_gnt_i=0, drop the outstanding flag and roll fpc back to the ungranted address, so it is re-requested.
REQ-020 SHALL push {addr, rdata} on grant of a non-discarded request; push and pop in the same cycle leave count unchanged.
REQ-021 SHALL pop when valid_o=1 and ready_i=1; valid_o = (count != 0); rdata_o/addr_o come straight from the head entry.
REQ-022 SHALL implement FSM IDLE -> RUN when req_i=1; RUN -> IDLE when req_i=0 and no request outstanding; in IDLE instr_req_o=0 and FIFO contents are held.
REQ-023 SHALL, on branch_i=1: empty FIFO that cycle, set fpc = {branch_addr_i[31:2],2'b00}, discard any response arriving next cycle, ignore same-cycle pop.
REQ-024 SHALL, on branch_i=1 with req_i=1, issue a request to the aligned target in the same cycle (instr_addr_o = aligned target, bypassing fpc).
REQ-025 SHALL never push when full; a grant with count=DEPTH is impossible under REQ-017, and an assertion SHALL flag it.
REQ-026 SHALL wrap FIFO read/write pointers modulo DEPTH; count range 0..DEPTH.

Reset
REQ-027 SHALL, on rst_ni=0 asynchronously: FSM=IDLE, fpc=BOOT_ADDR, count=0, pointers=0, outstanding=0, discard=0.
REQ-028 SHALL drive during reset: valid_o=0, instr_req_o=0, instr_addr_o=BOOT_ADDR, rdata_o=32'h00000013, addr_o=0.
REQ-029 SHALL discard any response arriving in the first cycle after reset release.

Verification
REQ-030 Reset release, req_i=1, memory always grants, ready_i=1 -> instr_addr_o 0x80,0x84,0x88...; valid_o first high in cycle 2 with addr_o=0x80.
REQ-031 ready_i=0, req_i=1 -> exactly 4 words buffered (0x80..0x8C), instr_req_o low thereafter, no overflow; raising ready_i drains in order.
REQ-032 Branch to 0x103 while 3 entries buffered and one outstanding -> valid_o=0 next cycle, late response dropped, next addr_o=0x100.
REQ-033 instr_gnt_i forced 0 for the request at 0x88 -> 0x88 re-requested, no gap or duplicate in delivered addresses.
REQ-034 rst_ni low mid-stream with count=2 -> valid_o=0 immediately (asynchronously); after release fetch restarts at 0x80.
REQ-035 fpc at 0xFFFFFFFC -> next request 0x00000000, delivered addr_o wraps identically.

Source files
------------

// File: rtl/instr_fetch_buf_if.sv
// instr_fetch_buf_if: core-side fetch handshake plus the memory fetch port
interface instr_fetch_buf_if;
  logic        req_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] rdata_o;
  logic [31:0] addr_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic [31:0] instr_rdata_i;
  modport slave (
    input  req_i, branch_i, branch_addr_i, ready_i, instr_gnt_i, instr_rdata_i,
    output valid_o, rdata_o, addr_o, instr_req_o, instr_addr_o
  );
  modport master (
    output req_i, branch_i, branch_addr_i, ready_i, instr_gnt_i, instr_rdata_i,
    input  valid_o, rdata_o, addr_o, instr_req_o, instr_addr_o
  );
endinterface

// File: rtl/instr_fetch_buf.sv
// instr_fetch_buf: prefetch FIFO fed by a single-outstanding fetch port, with branch redirect
module instr_fetch_buf #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BOOT_ADDR = 32'h80
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  instr_fetch_buf_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  typedef enum logic {IDLE, RUN} state_e;
  state_e        state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   oaddr_q, oaddr_d;
  logic          out_q, out_d;
  logic          disc_q, disc_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   mem_addr_q [DEPTH];
  logic [31:0]   mem_data_q [DEPTH];
  logic [31:0]   tgt;
  logic          miss, room, full, push, pop;
  // Fetch throttling, PC/rollback update, FIFO bookkeeping and head presentation
  always_comb begin
    tgt              = {bus.branch_addr_i[31:2], 2'b00};
    miss             = out_q && !bus.instr_gnt_i;
    room             = (cnt_q + CW'(out_q)) < CW'(DEPTH);
    full             = cnt_q == CW'(DEPTH);
    bus.instr_req_o  = state_q == RUN && bus.req_i && room && (bus.branch_i || !miss);
    bus.instr_addr_o = bus.instr_req_o && bus.branch_i ? tgt : fpc_q;
    push             = out_q && bus.instr_gnt_i && !disc_q && !bus.branch_i && !full;
    bus.valid_o      = cnt_q != '0;
    pop              = bus.valid_o && bus.ready_i && !bus.branch_i;
    bus.rdata_o      = bus.valid_o ? mem_data_q[rptr_q] : 32'h0000_0013;
    bus.addr_o       = bus.valid_o ? mem_addr_q[rptr_q] : 32'h0;
    state_d          = state_q == IDLE ? (bus.req_i ? RUN : IDLE)
                                       : (!bus.req_i && !out_q ? IDLE : RUN);
    fpc_d            = bus.branch_i ? tgt : miss ? oaddr_q
                     : bus.instr_req_o ? fpc_q + 32'd4 : fpc_q;
    oaddr_d          = bus.instr_req_o ? bus.instr_addr_o : oaddr_q;
    out_d            = bus.instr_req_o;
    disc_d           = bus.branch_i;
    cnt_d            = bus.branch_i ? '0 : cnt_q + CW'(push) - CW'(pop);
    wptr_d           = bus.branch_i ? '0 : wptr_q + AW'(push);
    rptr_d           = bus.branch_i ? '0 : rptr_q + AW'(pop);
  end
  // Control state, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      fpc_q   <= BOOT_ADDR;
      oaddr_q <= BOOT_ADDR;
      out_q   <= 1'b0;
      disc_q  <= 1'b0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      oaddr_q <= oaddr_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end
  // Entry storage; only read while valid, so it needs no reset
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_addr_q[wptr_q] <= oaddr_q;
      mem_data_q[wptr_q] <= bus.instr_rdata_i;
    end
  end
  // A grant arriving while full means the request throttle was violated
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(out_q && bus.instr_gnt_i && full));
endmodule

// File: tb/tb_instr_fetch_buf.sv
// tb_instr_fetch_buf: randomized scoreboard bench for the instruction prefetch buffer
module tb_instr_fetch_buf;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  instr_fetch_buf_if bus();
  instr_fetch_buf #(.DEPTH(4), .BOOT_ADDR(32'h80)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  int tests = 0;
  int fails = 0;
  int delivered = 0;
  int req88 = 0;
  logic [31:0] exp_q [$];
  logic [31:0] next_push = 32'h80;
  logic        pend_req = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  logic        gnt_rand = 1'b0;
  logic [31:0] miss_addr = 32'h1;
  logic        seen0 = 1'b0;
  logic        req = 1'b0, ready = 1'b0, br = 1'b0;
  logic [31:0] br_addr = 32'h0;
  // Memory contents: a fixed scramble of the word address
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic chkb(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask
  // One clock: memory answers last cycle's request, stimulus applied, request captured,
  // expected stream redirected on a branch and kept topped up with consecutive words
  task automatic cyc();
    @(negedge clk);
    bus.instr_gnt_i   = pend_req && pend_addr != miss_addr && (!gnt_rand || $urandom_range(0, 3) != 0);
    if (pend_req && pend_addr == miss_addr) miss_addr = 32'h1;
    bus.instr_rdata_i = bus.instr_gnt_i ? memf(pend_addr) : 32'hDEAD_BEEF;
    bus.req_i         = req;
    bus.ready_i       = ready;
    bus.branch_i      = br;
    bus.branch_addr_i = br_addr;
    #1;
    pend_req  = bus.instr_req_o;
    pend_addr = bus.instr_addr_o;
    if (pend_req) begin
      chk("fetch_align", {30'd0, pend_addr[1:0]}, 32'd0);
      if (pend_addr == 32'h88) req88++;
      if (pend_addr == 32'h0) seen0 = 1'b1;
    end
    if (br) begin
      exp_q.delete();
      next_push = {br_addr[31:2], 2'b00};
    end
    while (exp_q.size() < 16) begin
      exp_q.push_back(next_push);
      next_push += 32'd4;
    end
  endtask
  task automatic reset_dut();
    #2 rst_n = 1'b0;
    exp_q.delete();
    next_push = 32'h80;
    #1;
    chkb("rst_valid", bus.valid_o, 1'b0);
    chkb("rst_instr_req", bus.instr_req_o, 1'b0);
    chk("rst_instr_addr", bus.instr_addr_o, 32'h80);
    chk("rst_rdata", bus.rdata_o, 32'h13);
    chk("rst_addr", bus.addr_o, 32'h0);
    repeat (2) cyc();
    #2 rst_n = 1'b1;
  endtask
  task automatic check_boot();
    cyc();
    chkb("boot_c0_req", bus.instr_req_o, 1'b1);
    chk("boot_c0_addr", bus.instr_addr_o, 32'h80);
    chkb("boot_c0_valid", bus.valid_o, 1'b0);
    cyc();
    chk("boot_c1_addr", bus.instr_addr_o, 32'h84);
    chkb("boot_c1_valid", bus.valid_o, 1'b0);
    cyc();
    chk("boot_c2_addr", bus.instr_addr_o, 32'h88);
    chkb("boot_c2_valid", bus.valid_o, 1'b1);
    chk("boot_c2_head", bus.addr_o, 32'h80);
  endtask
  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.valid_o && n < 20) begin
      cyc();
      n++;
    end
    chkb(name, bus.valid_o, 1'b1);
  endtask
  // Monitor: every accepted head entry must be the next word of the expected stream
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.valid_o && bus.ready_i && !bus.branch_i) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard_empty: got %h, expected no delivery", bus.addr_o);
        end else begin
          e = exp_q.pop_front();
          chk("deliver_addr", bus.addr_o, e);
          chk("deliver_data", bus.rdata_o, memf(e));
        end
        delivered++;
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL timeout: got no end, expected finish");
    $fatal(1, "timeout");
  end
  initial begin : main
    int d0;
    bus.req_i = 1'b0; bus.branch_i = 1'b0; bus.branch_addr_i = 32'h0; bus.ready_i = 1'b0;
    bus.instr_gnt_i = 1'b0; bus.instr_rdata_i = 32'h0;
    #1;
    req = 1'b1; ready = 1'b1;
    reset_dut();
    check_boot();
    repeat (6) cyc();
    req = 1'b1; ready = 1'b0;
    reset_dut();
    check_boot();
    repeat (7) cyc();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chkb("full_req_low", bus.instr_req_o, 1'b0);
    end
    chk("full_head", bus.addr_o, 32'h80);
    req = 1'b0; ready = 1'b1;
    d0 = delivered;
    repeat (8) cyc();
    chk("full_drain_count", 32'(delivered - d0), 32'd4);
    chkb("full_drained", bus.valid_o, 1'b0);
    req = 1'b1; ready = 1'b0;
    reset_dut();
    check_boot();
    cyc();
    br = 1'b1; br_addr = 32'h103;
    cyc();
    chkb("br_full_noreq", bus.instr_req_o, 1'b0);
    br = 1'b0; ready = 1'b1;
    cyc();
    chkb("br_flush_valid", bus.valid_o, 1'b0);
    wait_valid("br_refill");
    chk("br_first_head", bus.addr_o, 32'h100);
    repeat (5) cyc();
    br = 1'b1; br_addr = 32'h2002;
    cyc();
    chkb("br_bypass_req", bus.instr_req_o, 1'b1);
    chk("br_bypass_addr", bus.instr_addr_o, 32'h2000);
    br = 1'b0;
    cyc();
    wait_valid("br2_refill");
    chk("br2_first_head", bus.addr_o, 32'h2000);
    miss_addr = 32'h88; req88 = 0;
    reset_dut();
    repeat (15) cyc();
    chk("miss_rereq_count", 32'(req88), 32'd2);
    seen0 = 1'b0;
    br = 1'b1; br_addr = 32'hFFFF_FFF7;
    cyc();
    br = 1'b0;
    repeat (12) cyc();
    chkb("wrap_fetch0", seen0, 1'b1);
    req = 1'b1; ready = 1'b0;
    reset_dut();
    check_boot();
    cyc();
    chkb("midrst_valid_before", bus.valid_o, 1'b1);
    reset_dut();
    check_boot();
    gnt_rand = 1'b1;
    d0 = delivered;
    for (int i = 0; i < 3000; i++) begin
      req = $urandom_range(0, 7) != 0;
      ready = $urandom_range(0, 2) != 0;
      br = $urandom_range(0, 39) == 0;
      br_addr = $urandom;
      cyc();
    end
    br = 1'b0; req = 1'b0; ready = 1'b1;
    repeat (20) cyc();
    chkb("rand_liveness", (delivered - d0) > 300, 1'b1);
    chkb("rand_drained", bus.valid_o, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
